// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional same-cycle write bypass and a
// per-register busy scoreboard (issue sets, writeback clears, set wins).
module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 4,
   parameter int NUM_WR     = 2,
   parameter int BYPASS     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic [NUM_WR-1:0]            iss_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] iss_addr,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
   output logic [ADDR_WIDTH:0]          busy_cnt
);

   localparam int NREG = 2**ADDR_WIDTH;

   logic [NREG-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [NREG-1:0]                 busy_q, busy_d;
   logic [ADDR_WIDTH:0]             busy_cnt_q, busy_cnt_d;

   // Writes are applied in ascending port order so the highest port wins;
   // issues are applied after writebacks so a new producer keeps the bit set.
   always_comb begin
      regs_d     = regs_q;
      busy_d     = busy_q;
      busy_cnt_d = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
            regs_d[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            busy_d[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
         end
      end
      for (int j = 0; j < NUM_WR; j++) begin
         if (iss_en[j] && iss_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)
            busy_d[iss_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
      for (int i = 1; i < NREG; i++)
         busy_cnt_d = busy_cnt_d + (ADDR_WIDTH+1)'(busy_d[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q     <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rdat;

      assign ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

      // Reset forces zero even if a write is presented while rst is high.
      always_comb begin
         rdat = regs_q[ra];
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0 &&
                   wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ra)
                  rdat = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         if (rst || ra == '0)
            rdat = '0;
      end

      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rdat;
      assign rd_busy[k] = busy_q[ra];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus and are
// checked every cycle against an array model, plus directed literal checks.
module tb_regfile_mp;
   localparam int DW = 32, AW = 5, NR = 4, NW = 2;

   logic              clk, rst;
   logic [NR*AW-1:0]  rd_addr;
   logic [NW-1:0]     iss_en, wr_en;
   logic [NW*AW-1:0]  iss_addr, wr_addr;
   logic [NW*DW-1:0]  wr_data;
   logic [NR*DW-1:0]  rd_data_b, rd_data_n;
   logic [NR-1:0]     rd_busy_b, rd_busy_n;
   logic [AW:0]       busy_cnt_b, busy_cnt_n;

   int total = 0;
   int bad   = 0;

   regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy_cnt(busy_cnt_b));

   regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy_cnt(busy_cnt_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: plain register and busy arrays.
   logic [DW-1:0] mreg [32];
   bit            mbusy[32];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            mreg[i]  <= '0;
            mbusy[i] <= 1'b0;
         end
      end else begin
         for (int j = 0; j < NW; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
               mreg[wr_addr[j*AW +: AW]]  <= wr_data[j*DW +: DW];
               mbusy[wr_addr[j*AW +: AW]] <= 1'b0;
            end
         for (int j = 0; j < NW; j++)
            if (iss_en[j] && iss_addr[j*AW +: AW] != 0)
               mbusy[iss_addr[j*AW +: AW]] <= 1'b1;
      end
   end

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      logic [DW-1:0] v;
      v = mreg[a];
      if (byp)
         for (int j = 0; j < NW; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
      if (rst || a == 0) v = '0;
      return v;
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      for (int i = 1; i < 32; i++) n += int'(mbusy[i]);
      return n;
   endfunction

   task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < NR; k++) begin
         cmp($sformatf("cyc_rd_b%0d", k), rd_data_b[k*DW +: DW], exp_rd(rd_addr[k*AW +: AW], 1'b1));
         cmp($sformatf("cyc_rd_n%0d", k), rd_data_n[k*DW +: DW], exp_rd(rd_addr[k*AW +: AW], 1'b0));
         cmp($sformatf("cyc_busy_b%0d", k), 32'(rd_busy_b[k]), 32'(mbusy[rd_addr[k*AW +: AW]]));
         cmp($sformatf("cyc_busy_n%0d", k), 32'(rd_busy_n[k]), 32'(mbusy[rd_addr[k*AW +: AW]]));
      end
      cmp("cyc_cnt_b", 32'(busy_cnt_b), 32'(exp_cnt()));
      cmp("cyc_cnt_n", 32'(busy_cnt_n), 32'(exp_cnt()));
   end

   task automatic clr();
      iss_en = '0; wr_en = '0; iss_addr = '0; wr_addr = '0; wr_data = '0;
   endtask
   task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en[p] = 1'b1; wr_addr[p*AW +: AW] = a; wr_data[p*DW +: DW] = d;
   endtask
   task automatic iss(input int p, input logic [AW-1:0] a);
      iss_en[p] = 1'b1; iss_addr[p*AW +: AW] = a;
   endtask
   task automatic rda(input int k, input logic [AW-1:0] a);
      rd_addr[k*AW +: AW] = a;
   endtask
   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; rd_addr = '0; clr();
      repeat (2) @(posedge clk);
      #1;
      cmp("rst_cnt", 32'(busy_cnt_b), 32'd0);
      cmp("rst_rd", rd_data_b[DW-1:0], 32'd0);
      rst = 1'b0;
      step();

      // async reset mid-cycle
      wr(0, 5'd5, 32'hDEADBEEF); iss(0, 5'd6);
      step(); clr(); rda(0, 5'd5); rda(1, 5'd6);
      #1;
      cmp("t1_pre_b", rd_data_b[DW-1:0], 32'hDEADBEEF);
      cmp("t1_pre_cnt", 32'(busy_cnt_b), 32'd1);
      rst = 1'b1;
      #1;
      cmp("t1_rd_b", rd_data_b[DW-1:0], 32'd0);
      cmp("t1_rd_n", rd_data_n[DW-1:0], 32'd0);
      cmp("t1_cnt", 32'(busy_cnt_b), 32'd0);
      cmp("t1_busy", 32'(rd_busy_b[1]), 32'd0);
      #1 rst = 1'b0;
      step();

      // write collision, highest port wins
      wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); rda(0, 5'd3);
      #1;
      cmp("t2_byp_now", rd_data_b[DW-1:0], 32'h22);
      cmp("t2_nobyp_now", rd_data_n[DW-1:0], 32'h0);
      step(); clr();
      #1;
      cmp("t2_b_next", rd_data_b[DW-1:0], 32'h22);
      cmp("t2_n_next", rd_data_n[DW-1:0], 32'h22);
      step();
      cmp("t2_b_later", rd_data_b[DW-1:0], 32'h22);

      // x0 is hardwired
      wr(0, 5'd0, 32'hFFFFFFFF); iss(0, 5'd0); rda(0, 5'd0);
      #1;
      cmp("t3_b_now", rd_data_b[DW-1:0], 32'h0);
      step(); clr();
      #1;
      cmp("t3_n", rd_data_n[DW-1:0], 32'h0);
      cmp("t3_busy", 32'(rd_busy_b[0]), 32'd0);
      cmp("t3_cnt", 32'(busy_cnt_b), 32'd0);

      // set beats clear
      iss(0, 5'd7);
      step(); clr(); rda(1, 5'd7);
      #1;
      cmp("t4_busy1", 32'(rd_busy_b[1]), 32'd1);
      cmp("t4_cnt1", 32'(busy_cnt_b), 32'd1);
      wr(0, 5'd7, 32'h55); iss(1, 5'd7);
      #1;
      cmp("t4_byp", rd_data_b[2*DW-1:DW], 32'h55);
      cmp("t4_nobyp", rd_data_n[2*DW-1:DW], 32'h0);
      step(); clr();
      #1;
      cmp("t4_busy2", 32'(rd_busy_b[1]), 32'd1);
      cmp("t4_cnt2", 32'(busy_cnt_b), 32'd1);
      cmp("t4_data2", rd_data_n[2*DW-1:DW], 32'h55);
      wr(0, 5'd7, 32'h77);
      step(); clr();
      #1;
      cmp("t4_busy3", 32'(rd_busy_b[1]), 32'd0);
      cmp("t4_cnt3", 32'(busy_cnt_b), 32'd0);
      cmp("t4_data3", rd_data_n[2*DW-1:DW], 32'h77);

      // fill and drain the scoreboard
      for (int c = 0; c < 16; c++) begin
         clr();
         iss(0, 5'(2*c+1));
         iss(1, (c == 15) ? 5'd31 : 5'(2*c+2));
         step();
      end
      clr();
      #1;
      cmp("t5_full", 32'(busy_cnt_b), 32'd31);
      for (int c = 0; c < 16; c++) begin
         clr();
         wr(0, 5'(2*c+1), 32'h1000 + 32'(2*c+1));
         wr(1, (c == 15) ? 5'd31 : 5'(2*c+2), 32'h2000 + 32'((c == 15) ? 31 : 2*c+2));
         step();
      end
      clr(); rda(0, 5'd31);
      #1;
      cmp("t5_empty", 32'(busy_cnt_b), 32'd0);
      cmp("t5_x31", rd_data_n[DW-1:0], 32'h201F);

      // all read ports on one bypassed write
      for (int k = 0; k < NR; k++) rda(k, 5'd9);
      wr(1, 5'd9, 32'hA5A5); wr(0, 5'd10, 32'h1234);
      #1;
      for (int k = 0; k < NR; k++) begin
         cmp($sformatf("t6_b%0d", k), rd_data_b[k*DW +: DW], 32'hA5A5);
         cmp($sformatf("t6_n%0d", k), rd_data_n[k*DW +: DW], 32'h1009);
      end
      step(); clr();
      #1;
      for (int k = 0; k < NR; k++)
         cmp($sformatf("t6_next%0d", k), rd_data_n[k*DW +: DW], 32'hA5A5);
      rda(2, 5'd10);
      #1;
      cmp("t6_x10", rd_data_n[3*DW-1:2*DW], 32'h1234);

      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
